// File: rtl/serial_adder.sv
// Digit-serial adder: adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock.
// Optional subtract mode (a - b) is enabled by defining SERIAL_ADDER_SUB_EN.
//
// state    | meaning
// ST_IDLE  | waiting for start
// ST_RUN   | one digit per cycle, busy=1
// ST_FIN   | one-cycle done pulse, start accepted here as well
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = $clog2(N) + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  generate
    if (WIDTH < 1 || (WIDTH % DIGIT) != 0) begin : g_param_chk
      $error("serial_adder: WIDTH must be >= 1 and a multiple of DIGIT");
    end
  endgenerate

  logic [1:0]       state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             am;
  logic             bm;

  logic [WIDTH-1:0] b_eff;
  logic             ci_eff;
  logic [DIGIT:0]   slice;
  logic [WIDTH-1:0] s_next;
  logic             last;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction is a + ~b + 1; the caller's ci is ignored in that mode.
  assign b_eff  = sub ? ~b : b;
  assign ci_eff = sub ? 1'b1 : ci;
`else
  assign b_eff  = b;
  assign ci_eff = ci;
`endif

  assign slice  = {1'b0, opa[DIGIT-1:0]} + {1'b0, opb[DIGIT-1:0]} + (DIGIT+1)'(carry);
  // New digit enters at the MSB end; written as a shift so DIGIT==WIDTH stays legal.
  assign s_next = WIDTH'({slice[DIGIT-1:0], s} >> DIGIT);
  assign last   = (cnt == CNT_W'(N - 1));

  assign busy = (state == ST_RUN);
  assign done = (state == ST_FIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      opa   <= '0;
      opb   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      am    <= 1'b0;
      bm    <= 1'b0;
      s     <= '0;
      co    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_FIN: begin
          if (start) begin
            opa   <= a;
            opb   <= b_eff;
            carry <= ci_eff;
            am    <= a[WIDTH-1];
            bm    <= b_eff[WIDTH-1];
            cnt   <= '0;
            state <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          carry <= slice[DIGIT];
          s     <= s_next;
          opa   <= opa >> DIGIT;
          opb   <= opb >> DIGIT;
          cnt   <= cnt + CNT_W'(1);
          if (last) begin
            state <= ST_FIN;
            co    <= slice[DIGIT];
            ovf   <= (am == bm) && (slice[DIGIT-1] != am);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: 8-bit/1-digit main instance, 4-bit sweep instance,
// and an 8-bit/4-digit instance.
module tb_serial_adder;

  logic clk;
  logic rst;

  logic       start, ci, busy, done, co, ovf;
  logic [7:0] a, b, s;
  logic       sub;

  logic       start4, ci4, busy4, done4, co4, ovf4;
  logic [3:0] a4, b4, s4;

  logic       startd, cid, busyd, doned, cod, ovfd;
  logic [7:0] ad, bd, sd;

  int n_tests;
  int n_fail;
  int lat;
  int busy_n;
  int done_seen;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .a(a), .b(b), .ci(ci), .busy(busy), .done(done), .s(s), .co(co), .ovf(ovf)
  );

  serial_adder #(.WIDTH(4), .DIGIT(1)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(1'b0),
`endif
    .a(a4), .b(b4), .ci(ci4), .busy(busy4), .done(done4), .s(s4), .co(co4), .ovf(ovf4)
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_dutd (
    .clk(clk), .rst(rst), .start(startd),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(1'b0),
`endif
    .a(ad), .b(bd), .ci(cid), .busy(busyd), .done(doned), .s(sd), .co(cod), .ovf(ovfd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start accepted on the next edge; operands are then scrambled to prove capture.
  task automatic launch(input logic [7:0] av, input logic [7:0] bv, input logic civ);
    a = av; b = bv; ci = civ; start = 1'b1;
    tick();
    start = 1'b0;
    a = 8'hE7; b = 8'h99; ci = ~civ;
  endtask

  // lat = cycle index (after the accepting edge) at which done is seen.
  task automatic wait_done();
    lat = 1;
    busy_n = 0;
    while (!done && lat < 40) begin
      if (busy) busy_n++;
      tick();
      lat++;
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b1; start = 1'b1; sub = 1'b0;
    a = 8'h5A; b = 8'h3C; ci = 1'b1;
    start4 = 1'b0; a4 = '0; b4 = '0; ci4 = 1'b0;
    startd = 1'b0; ad = '0; bd = '0; cid = 1'b0;

    // 1. reset holds everything low even with start asserted
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("reset_outputs", {20'd0, busy, done, co, ovf, s}, 32'd0);
    end
    rst = 1'b0; start = 1'b0;
    tick();
    chk("idle_after_reset", {30'd0, busy, done}, 32'd0);

    // 2. basic add with latency
    launch(8'h5A, 8'h3C, 1'b0);
    wait_done();
    chk("add1_latency", lat, 9);
    chk("add1_busy_cycles", busy_n, 8);
    chk("add1_result", {23'd0, co, ovf, s}, {23'd0, 1'b0, 1'b1, 8'h96});
    tick();
    chk("add1_done_pulse", {31'd0, done}, 32'd0);
    chk("add1_hold", {23'd0, co, ovf, s}, {23'd0, 1'b0, 1'b1, 8'h96});

    // 3. wrap with carry-in
    launch(8'hFF, 8'h01, 1'b1);
    wait_done();
    chk("wrap_result", {23'd0, co, ovf, s}, {23'd0, 1'b1, 1'b0, 8'h01});

    // 4. start mid-run ignored, then start on the done cycle accepted
    launch(8'h5A, 8'h3C, 1'b0);
    tick(); tick(); tick();
    a = 8'h11; b = 8'h22; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done();
    chk("ignore_start_latency", lat, 5);
    chk("ignore_start_result", {23'd0, co, ovf, s}, {23'd0, 1'b0, 1'b1, 8'h96});
    launch(8'h12, 8'h34, 1'b0);
    wait_done();
    chk("fin_start_latency", lat, 9);
    chk("fin_start_result", {23'd0, co, ovf, s}, {23'd0, 1'b0, 1'b0, 8'h46});

    // 5. reset in RUN cycle 4 aborts
    launch(8'h5A, 8'h3C, 1'b0);
    tick(); tick(); tick();
    chk("pre_abort_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_outputs", {20'd0, busy, done, co, ovf, s}, 32'd0);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) done_seen++;
      tick();
    end
    chk("abort_no_done", done_seen, 0);
    launch(8'h80, 8'h80, 1'b0);
    wait_done();
    chk("neg_ovf_result", {23'd0, co, ovf, s}, {23'd0, 1'b1, 1'b1, 8'h00});

    // exhaustive 4-bit sweep
    for (int i = 0; i < 512; i++) begin
      logic [4:0] sum;
      logic       ovf_exp;
      int         lat4;
      a4 = i[3:0]; b4 = i[7:4]; ci4 = i[8];
      sum = {1'b0, a4} + {1'b0, b4} + {4'd0, ci4};
      ovf_exp = (a4[3] == b4[3]) && (sum[3] != a4[3]);
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      a4 = ~a4; b4 = ~b4; ci4 = ~ci4;
      lat4 = 1;
      while (!done4 && lat4 < 20) begin
        tick();
        lat4++;
      end
      chk($sformatf("sweep4_%0d", i), {21'd0, lat4[4:0], co4, ovf4, s4},
          {21'd0, 5'd5, sum[4], ovf_exp, sum[3:0]});
    end

    // 6. DIGIT=4 instance
    ad = 8'h5A; bd = 8'h3C; cid = 1'b0; startd = 1'b1;
    tick();
    startd = 1'b0; ad = 8'h00; bd = 8'hFF;
    lat = 1;
    while (!doned && lat < 20) begin
      tick();
      lat++;
    end
    chk("digit4_latency", lat, 3);
    chk("digit4_result", {23'd0, cod, ovfd, sd}, {23'd0, 1'b0, 1'b1, 8'h96});

`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b1;
    launch(8'd10, 8'd20, 1'b0);
    wait_done();
    sub = 1'b0;
    chk("sub_result", {23'd0, co, ovf, s}, {23'd0, 1'b0, 1'b0, 8'hF6});
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
